// File: rtl/battleship_pkg.sv
// Shared types and helpers for the battleship lab blocks: board defaults,
// the shot resolver state encoding, cell indexing and occupancy popcount.
package battleship_pkg;

    localparam int DEF_ROWS = 5;
    localparam int DEF_COLS = 5;
    localparam int CELLS    = DEF_ROWS * DEF_COLS;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_REPORT = 3'd4,
        ST_OVER   = 3'd5
    } shot_state_t;

    function automatic logic [7:0] cell_idx(input logic [2:0] row,
                                            input logic [2:0] col,
                                            input logic [7:0] cols);
        return ({5'd0, row} * cols) + {5'd0, col};
    endfunction

    // Boards narrower than 32 cells are zero-extended by the caller.
    function automatic logic [5:0] popcount_cells(input logic [31:0] occ);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, occ[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Two-flop rising-edge detector with synchronous reset; the input is assumed
// already synchronized to clock.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic q1_r;
    logic q2_r;

    // Level history: q1 is the current sample, q2 the previous one.
    always_ff @(posedge clock) begin
        if (reset) begin
            q1_r <= 1'b0;
            q2_r <= 1'b0;
        end else begin
            q1_r <= level;
            q2_r <= q1_r;
        end
    end

    assign rise = q1_r & ~q2_r;

endmodule

// File: rtl/shot_resolver.sv
// Classifies fire presses against the placed fleet and keeps hit/miss maps and
// counters. Build option: SHOT_REPEAT_BLOCK_EN reports repeat shots and does not charge them.
module shot_resolver
    import battleship_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   active,
    input  logic                   fire,
    input  logic [2:0]             target_row,
    input  logic [2:0]             target_col,
    input  logic [ROWS*COLS-1:0]   board_occ,
    output logic                   result_valid,
    output logic                   result_hit,
    output logic                   result_repeat,
    output logic                   result_err,
    output logic [ROWS*COLS-1:0]   hit_map,
    output logic [ROWS*COLS-1:0]   miss_map,
    output logic [4:0]             hits_left,
    output logic [4:0]             shots_fired,
    output logic                   all_sunk,
    output logic                   busy
);

    localparam int         NCELL  = ROWS * COLS;
    localparam int         IDX_W  = $clog2(NCELL);
    localparam logic [3:0] ROWS_L = 4'(ROWS);
    localparam logic [3:0] COLS_L = 4'(COLS);

    shot_state_t      state_r, state_s;
    logic [2:0]       row_r, row_s, col_r, col_s;
    logic [NCELL-1:0] hit_map_r, hit_map_s, miss_map_r, miss_map_s;
    logic [4:0]       hits_left_r, hits_left_s, shots_r, shots_s;
    logic             valid_r, valid_s, hit_r, hit_s, rep_r, rep_s, err_r, err_s;
    logic             sunk_r, sunk_s, busy_r, busy_s;
    logic             fire_rise_s;
    logic [IDX_W-1:0] idx_s;
    logic [4:0]       occ_cnt_s;
    logic [4:0]       shots_inc_s;
    logic             out_of_range_s;

    rise_detect u_fire_rise (
        .clock (clock),
        .reset (reset),
        .level (fire),
        .rise  (fire_rise_s)
    );

    assign idx_s          = IDX_W'(cell_idx(row_r, col_r, 8'(COLS)));
    assign out_of_range_s = ({1'b0, row_r} >= ROWS_L) || ({1'b0, col_r} >= COLS_L);
    assign occ_cnt_s      = 5'(popcount_cells(32'(board_occ)));
    assign shots_inc_s    = (shots_r == 5'd31) ? shots_r : shots_r + 5'd1;

    // Next-state and next-output decode; dropping active overrides every state.
    always_comb begin
        state_s     = state_r;
        row_s       = row_r;
        col_s       = col_r;
        hit_map_s   = hit_map_r;
        miss_map_s  = miss_map_r;
        hits_left_s = hits_left_r;
        shots_s     = shots_r;
        valid_s     = 1'b0;
        hit_s       = hit_r;
        rep_s       = rep_r;
        err_s       = err_r;
        sunk_s      = sunk_r;
        busy_s      = 1'b0;
        if (!active) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_ARM;
                ST_ARM: begin
                    hit_map_s   = '0;
                    miss_map_s  = '0;
                    shots_s     = 5'd0;
                    hits_left_s = occ_cnt_s;
                    if (occ_cnt_s == 5'd0) begin
                        sunk_s  = 1'b1;
                        state_s = ST_OVER;
                    end else begin
                        sunk_s  = 1'b0;
                        state_s = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fire_rise_s) begin
                        row_s   = target_row;
                        col_s   = target_col;
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_CHECK: begin
                    valid_s = 1'b1;
                    hit_s   = 1'b0;
                    rep_s   = 1'b0;
                    err_s   = 1'b0;
                    state_s = ST_REPORT;
                    if (out_of_range_s) begin
                        err_s = 1'b1;
`ifdef SHOT_REPEAT_BLOCK_EN
                    end else if (hit_map_r[idx_s] || miss_map_r[idx_s]) begin
                        rep_s = 1'b1;
`else
                    // A re-shot hit cell is charged like a miss but leaves the maps alone.
                    end else if (hit_map_r[idx_s]) begin
                        shots_s = shots_inc_s;
`endif
                    end else if (board_occ[idx_s]) begin
                        hit_s            = 1'b1;
                        hit_map_s[idx_s] = 1'b1;
                        shots_s          = shots_inc_s;
                        if (hits_left_r != 5'd0) begin
                            hits_left_s = hits_left_r - 5'd1;
                        end else begin
                            hits_left_s = hits_left_r;
                        end
                    end else begin
                        miss_map_s[idx_s] = 1'b1;
                        shots_s           = shots_inc_s;
                    end
                end
                ST_REPORT: begin
                    if (hits_left_r == 5'd0) begin
                        sunk_s  = 1'b1;
                        state_s = ST_OVER;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_OVER: state_s = ST_OVER;
                default: state_s = ST_IDLE;
            endcase
        end
        busy_s = (state_s == ST_ARM) || (state_s == ST_CHECK) || (state_s == ST_REPORT);
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            row_r       <= 3'd0;
            col_r       <= 3'd0;
            hit_map_r   <= '0;
            miss_map_r  <= '0;
            hits_left_r <= 5'd0;
            shots_r     <= 5'd0;
            valid_r     <= 1'b0;
            hit_r       <= 1'b0;
            rep_r       <= 1'b0;
            err_r       <= 1'b0;
            sunk_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            row_r       <= row_s;
            col_r       <= col_s;
            hit_map_r   <= hit_map_s;
            miss_map_r  <= miss_map_s;
            hits_left_r <= hits_left_s;
            shots_r     <= shots_s;
            valid_r     <= valid_s;
            hit_r       <= hit_s;
            rep_r       <= rep_s;
            err_r       <= err_s;
            sunk_r      <= sunk_s;
            busy_r      <= busy_s;
        end
    end

    assign result_valid  = valid_r;
    assign result_hit    = hit_r;
    assign result_repeat = rep_r;
    assign result_err    = err_r;
    assign hit_map       = hit_map_r;
    assign miss_map      = miss_map_r;
    assign hits_left     = hits_left_r;
    assign shots_fired   = shots_r;
    assign all_sunk      = sunk_r;
    assign busy          = busy_r;

endmodule
